mailbox_port: RTL

Parametrised bidirectional mailbox between a host bus and a device bus. It replaces the single-register port with two independent FIFOs: host-to-device (H2D) and device-to-host (D2H). Each FIFO has registered occupancy, full/empty flags, sticky error flags and per-direction service flags. It sits between the CPU data bus and one peripheral, and keeps the HE/HRW and DE/DRW strobe protocol.

---
 rtl/mailbox_port.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/mailbox_port.sv
// Bidirectional host/device mailbox: two independent first-word-fall-through FIFOs
// with registered status, sticky error flags and tri-stated read buses.

module mailbox_fifo #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             push,
    input  logic             pop,
    input  logic             clr_err,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      count,
    output logic             ovf,
    output logic             udf
);
    localparam logic [AW:0] DEPTH_C = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             full_q, full_d;
    logic             empty_q, empty_d;
    logic             ovf_q, ovf_d;
    logic             udf_q, udf_d;
    logic             push_ok, pop_ok;

    // Acceptance looks only at pre-edge status, which is what resolves the
    // simultaneous push/pop corner cases on a full or empty FIFO.
    always_comb begin
        push_ok  = push & ~full_q;
        pop_ok   = pop & ~empty_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
        count_d = count_q + {{AW{1'b0}}, push_ok} - {{AW{1'b0}}, pop_ok};
        full_d  = (count_d == DEPTH_C);
        empty_d = (count_d == '0);
        // A new error in the same cycle as clr_err wins over the clear.
        ovf_d   = (push & full_q)  | (ovf_q & ~clr_err);
        udf_d   = (pop  & empty_q) | (udf_q & ~clr_err);
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
        end
    end

    // NOTE: the storage array has no reset; empty_q already masks stale contents.
    always_ff @(posedge clock) begin
        if (push_ok) mem_q[wr_ptr_q] <= wdata;
    end

    assign head  = empty_q ? '0 : mem_q[rd_ptr_q];
    assign full  = full_q;
    assign empty = empty_q;
    assign count = count_q;
    assign ovf   = ovf_q;
    assign udf   = udf_q;
endmodule

module mailbox_port #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  HE,
    input  logic                  HRW,
    input  logic                  DE,
    input  logic                  DRW,
    input  logic                  clr_err,
    inout  wire logic [WIDTH-1:0] host_dat,
    inout  wire logic [WIDTH-1:0] device_dat,
    output logic                  service,
    output logic                  host_irq,
    output logic                  h2d_full,
    output logic                  h2d_empty,
    output logic                  d2h_full,
    output logic                  d2h_empty,
    output logic [AW:0]           h2d_count,
    output logic [AW:0]           d2h_count,
    output logic                  h2d_ovf,
    output logic                  h2d_udf,
    output logic                  d2h_ovf,
    output logic                  d2h_udf
);
    logic             h_push, h_pop, d_push, d_pop;
    logic [WIDTH-1:0] h2d_head, d2h_head;

    assign h_push = HE & HRW;
    assign h_pop  = HE & ~HRW;
    assign d_push = DE & DRW;
    assign d_pop  = DE & ~DRW;

    mailbox_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW)) u_h2d (
        .clock   (clock),
        .reset_n (reset_n),
        .push    (h_push),
        .pop     (d_pop),
        .clr_err (clr_err),
        .wdata   (host_dat),
        .head    (h2d_head),
        .full    (h2d_full),
        .empty   (h2d_empty),
        .count   (h2d_count),
        .ovf     (h2d_ovf),
        .udf     (h2d_udf)
    );

    mailbox_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW)) u_d2h (
        .clock   (clock),
        .reset_n (reset_n),
        .push    (d_push),
        .pop     (h_pop),
        .clr_err (clr_err),
        .wdata   (device_dat),
        .head    (d2h_head),
        .full    (d2h_full),
        .empty   (d2h_empty),
        .count   (d2h_count),
        .ovf     (d2h_ovf),
        .udf     (d2h_udf)
    );

    // Each side's bus is driven only while that side pops.
    assign host_dat   = h_pop ? d2h_head : 'z;
    assign device_dat = d_pop ? h2d_head : 'z;

    assign service  = ~h2d_empty;
    assign host_irq = ~d2h_empty;
endmodule
